counter_arbiter: RTL
====================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter: LEN_W, default 4, width of counter value and requested lengths.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 REQ  input  2  per-requester count request, level; bit i = requester i.
REQ-005 LEN0  input  LEN_W  requested terminal count for requester 0; sampled at grant.
REQ-006 LEN1  input  LEN_W  requested terminal count for requester 1; sampled at grant.
REQ-007 CNT_OUT  input  LEN_W  current value of the shared counter.
REQ-008 CNT_TC  input  1  terminal-count flag of the shared counter (CNT_OUT all ones).
REQ-009 CNT_CLR  output  1  synchronous clear command to the counter.
REQ-010 CNT_EN  output  1  count-enable command to the counter.
REQ-011 GNT  output  2  one-hot grant; at most one bit high.
REQ-012 DONE  output  2  one-cycle completion pulse; bit i = requester i.
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 ERR  output  1  sticky counter-inconsistency flag.

Function
REQ-015 FSM states: IDLE, CLEAR, RUN, FINISH; registered state and outputs GNT, DONE, BUSY, ERR.
REQ-016 IDLE: with no REQ bit set, stay in IDLE with CNT_CLR=0, CNT_EN=0, GNT=0.
REQ-017 IDLE: with exactly one REQ bit set, grant that requester, latch its LEN, and go to CLEAR.
REQ-018 IDLE: with both REQ bits set, grant the requester not equal to the LAST pointer.
REQ-019 LAST pointer updates to the granted index on entry to FINISH.
REQ-020 CLEAR: lasts one cycle; CNT_CLR=1, CNT_EN=0, GNT held; go to RUN.
REQ-021 RUN: CNT_EN = (CNT_OUT != latched LEN), combinational; CNT_CLR=0; GNT held.
REQ-022 RUN: when CNT_OUT == latched LEN, go to FINISH; RUN lasts LEN+1 cycles.
REQ-023 Latched LEN=0: RUN lasts one cycle with CNT_EN=0.
REQ-024 FINISH: lasts one cycle; DONE[g]=1 for granted g; GNT held; CNT_EN=0; go to IDLE.
REQ-025 IDLE entry after FINISH clears GNT; a new grant is possible in that same IDLE cycle.
REQ-026 Timing: REQ sampled in IDLE at cycle t gives GNT from t+1, CNT_CLR at t+1, and DONE at t+LEN+3.
REQ-027 REQ deassertion or LEN change during CLEAR/RUN/FINISH is ignored; the run completes and DONE still pulses.
REQ-028 REQ still held after DONE counts as a new request; two held requests alternate strictly.
REQ-029 ERR is set if CNT_TC=1 in RUN while CNT_OUT != latched LEN, or if CNT_OUT != 0 in the first RUN cycle.
REQ-030 ERR does not alter sequencing and clears only on reset.

Reset
REQ-031 RESET=0 forces immediately: state IDLE, GNT=0, DONE=0, BUSY=0, ERR=0, CNT_EN=0, CNT_CLR=0, LAST=1 (requester 0 wins first tie).
REQ-032 Reset mid-run aborts without a DONE pulse; the counter is not cleared until the next CLEAR.
REQ-033 Reset deassertion is taken synchronously; the first possible grant is at the first rising edge with RESET=1.

Verification
REQ-034 Single request: REQ=01, LEN0=3 -> GNT=01, one CNT_CLR cycle, CNT_EN high 3 cycles (CNT_OUT 0->3), DONE=01 at t+6, BUSY low at t+7.
REQ-035 Tie: REQ=11 held after reset, LEN0=2, LEN1=1 -> grants 01,10,01,... alternating; DONE pulses alternate.
REQ-036 Zero length: REQ=10, LEN1=0 -> CLEAR, one RUN cycle with CNT_EN=0, DONE=10 at t+3.
REQ-037 Full range: LEN0=15 -> CNT_EN high 15 cycles; CNT_TC coincides with CNT_OUT=15; DONE=01, ERR=0.
REQ-038 Mid-run withdrawal and reset: drop REQ during RUN -> DONE still pulses; assert RESET=0 during RUN -> all outputs 0 immediately, no DONE.
REQ-039 Fault: force CNT_TC=1 with CNT_OUT=5 and LEN=9 in RUN -> ERR=1 and stays 1 until reset; the run completes normally.

Source files
------------

// File: rtl/counter_arbiter.sv
// Two-requester arbiter that borrows a shared external counter: clears it, counts it up
// to the granted requester's latched length, then pulses DONE for that requester.
module counter_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_i,
  input  logic [LEN_W-1:0] len0_i,
  input  logic [LEN_W-1:0] len1_i,
  input  logic [LEN_W-1:0] cnt_out_i,
  input  logic             cnt_tc_i,
  output logic             cnt_clr_o,
  output logic             cnt_en_o,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic             busy_o,
  output logic             err_o
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_FINISH} state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             last_q, last_d;
  logic             first_q, first_d;
  logic             sel;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = 2'b00;
    err_d     = err_q;
    len_d     = len_q;
    last_d    = last_q;
    first_d   = 1'b0;
    sel       = 1'b0;
    cnt_clr_o = 1'b0;
    cnt_en_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        gnt_d = 2'b00;
        if (req_i != 2'b00) begin
          // On a tie the requester that did not finish last wins.
          sel     = (req_i == 2'b11) ? ~last_q : req_i[1];
          gnt_d   = sel ? 2'b10 : 2'b01;
          len_d   = sel ? len1_i : len0_i;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_clr_o = 1'b1;
        first_d   = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        cnt_en_o = (cnt_out_i != len_q);
        if ((cnt_tc_i && (cnt_out_i != len_q)) || (first_q && (cnt_out_i != '0)))
          err_d = 1'b1;
        if (cnt_out_i == len_q) begin
          state_d = S_FINISH;
          done_d  = gnt_q;
          last_d  = gnt_q[1];
        end
      end
      S_FINISH: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
      last_q  <= 1'b1;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      len_q   <= len_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign err_o  = err_q;

endmodule
